// File: rtl/io_out_fifo_if.sv
// io_out_fifo_if: CPU control strobes/address plus sink valid/ready handshake for io_out_fifo.
interface io_out_fifo_if #(parameter int WIDTH = 16);
    logic [15:0]      memAddr;
    logic             we_L;
    logic             re_L;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    modport master (output memAddr, we_L, re_L, out_ready, input out_data, out_valid, overflow);
    modport slave (input memAddr, we_L, re_L, out_ready, output out_data, out_valid, overflow);
endinterface

// File: rtl/io_out_fifo.sv
// io_out_fifo: store-captured output FIFO with pollable status word; IO_FIFO_STATS_EN adds a push counter at STAT_ADDR+2.
module io_out_fifo #(
    parameter int          WIDTH     = 16,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] IO_ADDR   = 16'h0610,
    parameter logic [15:0] STAT_ADDR = 16'h0612
) (
    input  logic          clock,
    input  logic          reset,
    inout  wire  [15:0]   dataBus,
    io_out_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             overflow_q, full, empty, push_req, push, pop, drop, stat_rd;
    logic             rd_en;
    logic [15:0]      status, rd_word;
    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign push_req = !bus.we_L && bus.memAddr == IO_ADDR;
    assign pop      = !empty && bus.out_ready;
    // a pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign stat_rd  = !bus.re_L && bus.memAddr == STAT_ADDR;
    assign status   = {overflow_q, full, empty, 6'b0, 7'(count)};
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];
    assign bus.overflow  = overflow_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            count      <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow_q <= drop ? 1'b1 : stat_rd ? 1'b0 : overflow_q;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset && push) mem[wr_ptr] <= WIDTH'(dataBus);
    end
`ifdef IO_FIFO_STATS_EN
    logic [15:0] push_cnt;
    logic        cnt_rd;
    assign cnt_rd = !bus.re_L && bus.memAddr == STAT_ADDR + 16'd2;
    always_ff @(posedge clock) begin
        if (reset) push_cnt <= '0;
        else if (push && push_cnt != 16'hFFFF) push_cnt <= push_cnt + 16'd1;
    end
    always_comb begin
        rd_en   = bus.we_L && (stat_rd || cnt_rd);
        rd_word = cnt_rd ? push_cnt : status;
    end
`else
    always_comb begin
        rd_en   = bus.we_L && stat_rd;
        rd_word = status;
    end
`endif
    // never drive while the CPU is storing, so the bus cannot contend
    assign dataBus = rd_en ? rd_word : 16'hzzzz;
endmodule

// File: tb/tb_io_out_fifo.sv
// tb_io_out_fifo: directed self-checking bench for io_out_fifo (DEPTH=8).
module tb_io_out_fifo;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    wire  [15:0] data_bus;
    logic        drv_en = 1'b0;
    logic [15:0] drv_val = '0;
    int          total = 0;
    int          bad = 0;
    int          drops = 0;
    logic [15:0] q[$];
    always #5 clock = ~clock;
    assign data_bus = drv_en ? drv_val : 16'hzzzz;
    io_out_fifo_if #(.WIDTH(16)) bus();
    io_out_fifo dut (.clock(clock), .reset(reset), .dataBus(data_bus), .bus(bus));
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // released bus reads as 0 in two-state simulation and as Z elsewhere
    function automatic logic [15:0] bus_val();
        return (^data_bus === 1'bx) ? 16'h0 : data_bus;
    endfunction
    task automatic idle();
        bus.memAddr = '0;
        bus.we_L = 1'b1;
        bus.re_L = 1'b1;
        drv_en = 1'b0;
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic store(input logic [15:0] v);
        bus.memAddr = 16'h0610;
        bus.we_L = 1'b0;
        drv_en = 1'b1;
        drv_val = v;
        tick();
        idle();
    endtask
    task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        bus.memAddr = addr;
        bus.re_L = 1'b0;
        #1;
        chk(tag, bus_val(), exp);
        tick();
        idle();
    endtask
    initial begin
        logic do_push;
        logic do_pop;
        idle();
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", 16'(bus.out_valid), 16'h0);
        chk("rst_data", bus.out_data, 16'h0);
        chk("rst_ovf", 16'(bus.overflow), 16'h0);
        chk("rst_bus", bus_val(), 16'h0);
        rd("t1_empty", 16'h0612, 16'h2000);
        store(16'hBEEF);
        chk("t1_valid", 16'(bus.out_valid), 16'h1);
        chk("t1_data", bus.out_data, 16'hBEEF);
        rd("t1_stat", 16'h0612, 16'h0001);
        rd("t1_io_z", 16'h0610, 16'h0000);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t1_drained", 16'(bus.out_valid), 16'h0);
        chk("t1_data0", bus.out_data, 16'h0);
        for (int i = 1; i <= 8; i++) store(16'(i));
        store(16'h0009);
        chk("t2_ovf", 16'(bus.overflow), 16'h1);
        rd("t2_stat", 16'h0612, 16'hC008);
        rd("t2_clr", 16'h0612, 16'h4008);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("t2_drain", bus.out_data, 16'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("t2_empty", 16'(bus.out_valid), 16'h0);
        for (int i = 0; i < 8; i++) store(16'h0011 + 16'(i));
        bus.out_ready = 1'b1;
        store(16'h1234);
        bus.out_ready = 1'b0;
        chk("t3_ovf", 16'(bus.overflow), 16'h0);
        rd("t3_stat", 16'h0612, 16'h4008);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("t3_drain", bus.out_data, 16'h0012 + 16'(i));
            tick();
        end
        chk("t3_last", bus.out_data, 16'h1234);
        tick();
        bus.out_ready = 1'b0;
        chk("t3_empty", 16'(bus.out_valid), 16'h0);
        for (int k = 0; k < 40; k++) begin
            do_push = k < 30 && (k % 4) != 3;
            bus.out_ready = k >= 6 && (k % 3) != 0;
            if (do_push) begin
                bus.memAddr = 16'h0610;
                bus.we_L = 1'b0;
                drv_en = 1'b1;
                drv_val = 16'h0200 + 16'(k);
            end else idle();
            chk("t4_valid", 16'(bus.out_valid), 16'(q.size() > 0));
            if (q.size() > 0) chk("t4_data", bus.out_data, q[0]);
            @(posedge clock);
            do_pop = bus.out_ready && q.size() > 0;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < 8) q.push_back(16'h0200 + 16'(k));
                else drops++;
            end
            #1;
        end
        idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            chk("t4_drain", bus.out_data, q.pop_front());
            tick();
        end
        bus.out_ready = 1'b0;
        chk("t4_empty", 16'(bus.out_valid), 16'h0);
        rd("t4_stat", 16'h0612, drops > 0 ? 16'hA000 : 16'h2000);
        for (int i = 0; i < 8; i++) store(16'h0030 + 16'(i));
        store(16'h003F);
        chk("t5_ovf_set", 16'(bus.overflow), 16'h1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        store(16'h0055);
        reset = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5_valid", 16'(bus.out_valid), 16'h0);
        chk("t5_ovf", 16'(bus.overflow), 16'h0);
        chk("t5_data", bus.out_data, 16'h0);
        rd("t5_stat", 16'h0612, 16'h2000);
        store(16'h00AA);
        chk("t5_first", bus.out_data, 16'h00AA);
        for (int i = 1; i < 8; i++) store(16'h0060 + 16'(i));
        store(16'h0068);
`ifdef IO_FIFO_STATS_EN
        rd("t6_cnt", 16'h0614, 16'h0008);
        rd("t6_cnt_hold", 16'h0614, 16'h0008);
`else
        rd("t6_cnt_z", 16'h0614, 16'h0000);
`endif
        rd("t6_stat", 16'h0612, 16'hC008);
        bus.memAddr = 16'h0612;
        bus.re_L = 1'b0;
        bus.we_L = 1'b0;
        #1;
        chk("t6_no_contend", bus_val(), 16'h0000);
        idle();
        chk("t6_head", bus.out_data, 16'h00AA);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
